// File: rtl/hdc_pipe_pkg.sv
// rtl/hdc_pipe_pkg.sv - shared types and constants for the hypervector pipeline slices
package hdc_pipe_pkg;

    // Number of beats a skid slice can hold (main + skid register).
    localparam int SLICE_DEPTH = 2;

    // Occupancy is wide enough to count 0..SLICE_DEPTH.
    typedef logic [$clog2(SLICE_DEPTH + 1)-1:0] occ_t;

    // State value equals the number of beats held, so occupancy is a plain cast.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

    function automatic occ_t to_occ(input slice_state_t s);
        return occ_t'(s);
    endfunction

endpackage

// File: rtl/skid_slice.sv
// rtl/skid_slice.sv - registered valid/ready elastic slice with main+skid buffer, flush and occupancy
module skid_slice
    import hdc_pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ
);

    slice_state_t  state;
    slice_state_t  state_nxt;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          s_fire;
    logic          m_fire;
    logic          load_main;
    logic          load_skid;
    logic          main_from_skid;

    // Handshake flags and outputs are pure decodes of the state register, so
    // s_ready never depends combinationally on m_ready.
    assign s_ready = (state != FULL);
    assign m_valid = (state != EMPTY);
    assign m_data  = main_q;
    assign occ     = to_occ(state);
    assign s_fire  = s_valid & s_ready;
    assign m_fire  = m_valid & m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and data-register load selection; flush overrides every handshake.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (s_fire) begin
                    load_main = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (s_fire && m_fire) begin
                    load_main = 1'b1;
                end else if (s_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (m_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (m_fire) begin
                    main_from_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // Main and skid payload registers; they change only on an accepted beat
    // or when the skid beat advances into main.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= s_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_skid_slice.sv
// tb/tb_skid_slice.sv - self-checking bench for skid_slice with a queue-based reference model
module tb_skid_slice;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    occ;

    int checks;
    int errors;

    logic [DW-1:0] model_q[$];

    skid_slice #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .occ     (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded FIFO of at most two beats. Acceptance depends
    // only on how many beats are held; flush empties it after any consumption.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            automatic bit sf = s_valid && (model_q.size() < 2);
            automatic bit mf = m_ready && (model_q.size() > 0);
            if (mf) void'(model_q.pop_front());
            if (flush) model_q.delete();
            else if (sf) model_q.push_back(s_data);
        end
    end

    // Compare DUT outputs against the model every falling edge.
    always @(negedge clk) begin
        chk("model_m_valid", {31'd0, m_valid}, {31'd0, model_q.size() > 0});
        chk("model_s_ready", {31'd0, s_ready}, {31'd0, model_q.size() < 2});
        chk("model_occ", {30'd0, occ}, 32'(model_q.size()));
        if (model_q.size() > 0) chk("model_m_data", m_data, model_q[0]);
    end

    // Present one cycle of inputs, then return 1 time unit after the rising edge.
    task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset held three cycles, then idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
            chk("rst_occ", {30'd0, occ}, 32'd0);
            chk("rst_m_data", m_data, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
            chk("idle_m_valid", {31'd0, m_valid}, 32'd0);
            chk("idle_m_data", m_data, 32'd0);
        end

        // Streaming at full rate.
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        chk("stream_d0", m_data, 32'h11);
        chk("stream_occ0", {30'd0, occ}, 32'd1);
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        chk("stream_d1", m_data, 32'h22);
        chk("stream_rdy1", {31'd0, s_ready}, 32'd1);
        drive(1'b1, 32'h33, 1'b1, 1'b0);
        chk("stream_d2", m_data, 32'h33);
        chk("stream_occ2", {30'd0, occ}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_drained", {30'd0, occ}, 32'd0);

        // Backpressure fills main and skid.
        drive(1'b1, 32'hA0, 1'b0, 1'b0);
        drive(1'b1, 32'hA1, 1'b0, 1'b0);
        chk("bp_occ", {30'd0, occ}, 32'd2);
        chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
        chk("bp_hold", m_data, 32'hA0);
        drive(1'b1, 32'hA1, 1'b0, 1'b0);
        chk("bp_hold2", m_data, 32'hA0);

        // FULL with s_valid and m_ready: B2 is refused this cycle, accepted next.
        drive(1'b1, 32'hB2, 1'b1, 1'b0);
        chk("full_skid_out", m_data, 32'hA1);
        chk("full_ready_back", {31'd0, s_ready}, 32'd1);
        chk("full_occ", {30'd0, occ}, 32'd1);
        drive(1'b1, 32'hB2, 1'b1, 1'b0);
        chk("full_b2_out", m_data, 32'hB2);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("full_drained", {31'd0, m_valid}, 32'd0);

        // Flush while FULL, with a beat offered in the flush cycle.
        drive(1'b1, 32'hC0, 1'b0, 1'b0);
        drive(1'b1, 32'hC1, 1'b0, 1'b0);
        drive(1'b1, 32'hC2, 1'b0, 1'b1);
        chk("flush_occ", {30'd0, occ}, 32'd0);
        chk("flush_m_valid", {31'd0, m_valid}, 32'd0);
        chk("flush_s_ready", {31'd0, s_ready}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_c2", {31'd0, m_valid}, 32'd0);

        // Flush in BUSY coinciding with a downstream consume.
        drive(1'b1, 32'hE0, 1'b0, 1'b0);
        drive(1'b1, 32'hE1, 1'b1, 1'b1);
        chk("flush_busy_occ", {30'd0, occ}, 32'd0);

        // Asynchronous reset while FULL, between clock edges.
        drive(1'b1, 32'hF0, 1'b0, 1'b0);
        drive(1'b1, 32'hF1, 1'b0, 1'b0);
        chk("pre_rst_occ", {30'd0, occ}, 32'd2);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("arst_occ", {30'd0, occ}, 32'd0);
        chk("arst_m_data", m_data, 32'd0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'hD0, 1'b1, 1'b0);
        chk("post_rst_d0", m_data, 32'hD0);
        chk("post_rst_valid", {31'd0, m_valid}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Mixed stall pattern exercising every transition against the model.
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 0, 32'h100 + 32'(i), (i % 5) < 2, i == 29);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("final_empty", {30'd0, occ}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
